// File: rtl/qspi_arbiter_ctrl.sv
// Two-port QSPI flash/PSRAM arbiter: port 0 (ifetch, read-only) and port 1 (data, read/write).
// Round-robin grant, quad-I/O 0xEB read / 0x38 write, little-endian 32-bit words.
module qspi_arbiter_ctrl #(
   parameter int unsigned DUMMY_CYCLES = 4,
   parameter int unsigned CS_HIGH      = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic [23:0] p0_addr,
   output logic        p0_ack,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [23:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_ack,
   output logic [31:0] p1_rdata,
   output logic        spi_csb,
   output logic        spi_sclk,
   output logic [3:0]  spi_io_out,
   output logic [3:0]  spi_io_oe,
   input  logic [3:0]  spi_io_in
);

   typedef enum logic [2:0] {
      StIdle, StCmd, StAddr, StMode, StDummy, StData, StGap
   } state_t;

   localparam logic [7:0] DummyLast = 8'(DUMMY_CYCLES - 1);
   localparam logic [7:0] GapLast   = 8'((CS_HIGH == 0) ? 0 : CS_HIGH - 1);

   state_t      state_q, state_d;
   logic        phase_q, phase_d;   // 0 = SPI clock low phase, 1 = high phase
   logic [7:0]  cnt_q, cnt_d;
   logic        gnt_q, gnt_d;
   logic        last_q, last_d;
   logic        we_q, we_d;
   logic [23:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rd_q, rd_d;
   logic        ack_q, ack_d;
   logic [31:0] p0_rdata_q, p0_rdata_d;
   logic [31:0] p1_rdata_q, p1_rdata_d;
   logic [4:0]  nib_idx;
   logic [7:0]  cmd_byte;

   // Nibble n of the word: byte n/2, high nibble first within each byte.
   assign nib_idx  = {cnt_q[2:1], ~cnt_q[0], 2'b00};
   assign cmd_byte = we_q ? 8'h38 : 8'hEB;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         phase_q    <= 1'b0;
         cnt_q      <= 8'd0;
         gnt_q      <= 1'b0;
         last_q     <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= 24'd0;
         wdata_q    <= 32'd0;
         rd_q       <= 32'd0;
         ack_q      <= 1'b0;
         p0_rdata_q <= 32'd0;
         p1_rdata_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         ack_q      <= ack_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      cnt_d      = cnt_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      ack_d      = 1'b0;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;

      if (state_q == StIdle) begin
         if (p0_req || p1_req) begin
            gnt_d  = (p0_req && p1_req) ? ~last_q : p1_req;
            last_d = gnt_d;
            if (gnt_d) begin
               we_d    = p1_we;
               addr_d  = p1_addr;
               wdata_d = p1_wdata;
            end else begin
               we_d    = 1'b0;
               addr_d  = p0_addr;
               wdata_d = 32'd0;
            end
            state_d = StCmd;
            phase_d = 1'b0;
            cnt_d   = 8'd0;
         end
      end else if (state_q == StGap) begin
         if (cnt_q >= GapLast) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         phase_d = ~phase_q;
         // Everything advances on the edge that ends a high phase.
         if (phase_q) begin
            cnt_d = cnt_q + 8'd1;
            if (state_q == StData && !we_q) rd_d[nib_idx +: 4] = spi_io_in;
            if (state_q == StAddr) addr_d = {addr_q[19:0], 4'h0};
            case (state_q)
               StCmd: if (cnt_q == 8'd7) begin
                  state_d = StAddr;
                  cnt_d   = 8'd0;
               end
               StAddr: if (cnt_q == 8'd5) begin
                  state_d = we_q ? StData : StMode;
                  cnt_d   = 8'd0;
               end
               StMode: if (cnt_q == 8'd1) begin
                  state_d = (DUMMY_CYCLES == 0) ? StData : StDummy;
                  cnt_d   = 8'd0;
               end
               StDummy: if (cnt_q == DummyLast) begin
                  state_d = StData;
                  cnt_d   = 8'd0;
               end
               StData: if (cnt_q == 8'd7) begin
                  state_d = StGap;
                  cnt_d   = 8'd0;
                  ack_d   = 1'b1;
                  if (!we_q) begin
                     if (gnt_q) p1_rdata_d = rd_d;
                     else       p0_rdata_d = rd_d;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      spi_csb    = 1'b1;
      spi_sclk   = 1'b0;
      spi_io_out = 4'h0;
      spi_io_oe  = 4'h0;
      unique case (state_q)
         StCmd: begin
            spi_csb    = 1'b0;
            spi_sclk   = phase_q;
            spi_io_oe  = 4'b0001;
            spi_io_out = {3'b000, cmd_byte[~cnt_q[2:0]]};
         end
         StAddr: begin
            spi_csb    = 1'b0;
            spi_sclk   = phase_q;
            spi_io_oe  = 4'b1111;
            spi_io_out = addr_q[23:20];
         end
         StMode: begin
            spi_csb   = 1'b0;
            spi_sclk  = phase_q;
            spi_io_oe = 4'b1111;
         end
         StDummy: begin
            spi_csb  = 1'b0;
            spi_sclk = phase_q;
         end
         StData: begin
            spi_csb    = 1'b0;
            spi_sclk   = phase_q;
            spi_io_oe  = we_q ? 4'b1111 : 4'b0000;
            spi_io_out = we_q ? wdata_q[nib_idx +: 4] : 4'h0;
         end
         default: ;
      endcase
   end

   assign p0_ack   = ack_q & ~gnt_q;
   assign p1_ack   = ack_q & gnt_q;
   assign p0_rdata = p0_rdata_q;
   assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_qspi_arbiter_ctrl.sv
// Directed bench for qspi_arbiter_ctrl with a behavioural quad-SPI memory device.
module tb_qspi_arbiter_ctrl;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        p0_req = 1'b0;
   logic [23:0] p0_addr = 24'd0;
   logic        p0_ack;
   logic [31:0] p0_rdata;
   logic        p1_req = 1'b0;
   logic        p1_we = 1'b0;
   logic [23:0] p1_addr = 24'd0;
   logic [31:0] p1_wdata = 32'd0;
   logic        p1_ack;
   logic [31:0] p1_rdata;
   logic        spi_csb;
   logic        spi_sclk;
   logic [3:0]  spi_io_out;
   logic [3:0]  spi_io_oe;
   logic [3:0]  spi_io_in = 4'h0;

   int total = 0;
   int bad = 0;

   qspi_arbiter_ctrl #(.DUMMY_CYCLES(D), .CS_HIGH(2)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_io_out(spi_io_out),
      .spi_io_oe(spi_io_oe), .spi_io_in(spi_io_in)
   );

   always #5 clk = ~clk;

   // Device model: samples io on sclk high, drives read nibbles during the high phase.
   logic [7:0]  mem [0:4095];
   bit          mem_init = 1'b0;
   bit          in_tx = 1'b0;
   int          k, low_cnt, oe_err, n_nib;
   logic [7:0]  m_cmd;
   logic [23:0] m_addr, a;
   logic [3:0]  exp_oe;
   int          last_low = 0, last_oe_err = 0, tim_err = 0, idle_err = 0;
   logic [7:0]  last_cmd = 8'h00;
   logic [23:0] last_addr = 24'h0;
   logic        prev_sclk = 1'b0;
   logic [3:0]  prev_out = 4'h0, prev_oe = 4'h0;

   always @(negedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
         mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
         mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hB2; mem[12'h000] = 8'hC3; mem[12'h001] = 8'hD4;
         mem_init = 1'b1;
      end
      if (spi_sclk && (spi_io_out !== prev_out || spi_io_oe !== prev_oe)) tim_err++;
      if (spi_csb) begin
         if (spi_sclk || spi_io_oe != 4'h0 || spi_io_out != 4'h0) idle_err++;
         if (in_tx) begin
            last_low = low_cnt; last_cmd = m_cmd; last_addr = m_addr; last_oe_err = oe_err;
            in_tx = 1'b0;
         end
         spi_io_in = 4'h0;
      end else begin
         if (!in_tx) begin
            in_tx = 1'b1; low_cnt = 0; k = 0; oe_err = 0; m_cmd = 8'h00; m_addr = 24'h0;
         end
         low_cnt++;
         if (spi_sclk && !prev_sclk) begin
            if (k < 8) m_cmd = {m_cmd[6:0], spi_io_out[0]};
            else if (k < 14) m_addr = {m_addr[19:0], spi_io_out};
            if (k < 8) exp_oe = 4'b0001;
            else if (m_cmd == 8'h38 || k < 16) exp_oe = 4'b1111;
            else exp_oe = 4'b0000;
            if (spi_io_oe !== exp_oe) oe_err++;
            if (m_cmd == 8'h38 && k >= 14 && k < 22) begin
               n_nib = k - 14;
               a = m_addr + 24'(n_nib / 2);
               if (n_nib % 2 == 0) mem[a[11:0]][7:4] = spi_io_out;
               else                mem[a[11:0]][3:0] = spi_io_out;
            end
            if (m_cmd == 8'hEB && k >= 16 + D && k < 24 + D) begin
               n_nib = k - 16 - D;
               a = m_addr + 24'(n_nib / 2);
               spi_io_in = (n_nib % 2 == 0) ? mem[a[11:0]][7:4] : mem[a[11:0]][3:0];
            end else begin
               spi_io_in = 4'h0;
            end
            k++;
         end
      end
      prev_sclk = spi_sclk;
      prev_out  = spi_io_out;
      prev_oe   = spi_io_oe;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one request at the next negedge (cycle 0) and waits for its ack.
   task automatic do_txn(input bit port, input bit we, input logic [23:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat,
                         output int csb_fall);
      @(negedge clk);
      if (port) begin
         p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
      end else begin
         p0_req = 1'b1; p0_addr = addr;
      end
      lat = -1; csb_fall = -1; rd = 32'h0;
      for (int n = 1; n <= 200 && lat < 0; n++) begin
         @(negedge clk);
         if (csb_fall < 0 && !spi_csb) csb_fall = n;
         if (port ? p1_ack : p0_ack) begin
            lat = n;
            rd = port ? p1_rdata : p0_rdata;
            if (port) p1_req = 1'b0; else p0_req = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   logic [31:0] rd;
   int          lat, cf, nack;
   int          ack_t [0:2];
   bit          ack_p [0:2];
   logic [31:0] ack_d [0:2];
   bit          seen;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_csb", 32'(spi_csb), 32'd1);
      chk("reset_sclk", 32'(spi_sclk), 32'd0);
      chk("reset_oe", 32'(spi_io_oe), 32'd0);
      chk("reset_out", 32'(spi_io_out), 32'd0);
      chk("reset_ack", 32'({p0_ack, p1_ack}), 32'd0);
      chk("reset_rdata0", p0_rdata, 32'd0);
      chk("reset_rdata1", p1_rdata, 32'd0);
      reset = 1'b0;

      do_txn(1'b0, 1'b0, 24'h000100, 32'h0, rd, lat, cf);
      chk("rd_csb_fall", 32'(cf), 32'd1);
      chk("rd_ack_cycle", 32'(lat), 32'd57);
      chk("rd_data", rd, 32'h44332211);
      chk("rd_cmd", 32'(last_cmd), 32'hEB);
      chk("rd_addr", 32'(last_addr), 32'h000100);
      chk("rd_low_len", 32'(last_low), 32'd56);
      chk("rd_oe_seq", 32'(last_oe_err), 32'd0);

      do_txn(1'b1, 1'b1, 24'h000200, 32'hDEADBEEF, rd, lat, cf);
      chk("wr_ack_cycle", 32'(lat), 32'd45);
      chk("wr_cmd", 32'(last_cmd), 32'h38);
      chk("wr_addr", 32'(last_addr), 32'h000200);
      chk("wr_low_len", 32'(last_low), 32'd44);
      chk("wr_oe_seq", 32'(last_oe_err), 32'd0);

      do_txn(1'b1, 1'b0, 24'h000200, 32'h0, rd, lat, cf);
      chk("rb_ack_cycle", 32'(lat), 32'd57);
      chk("rb_data", rd, 32'hDEADBEEF);
      chk("p0_rdata_hold", p0_rdata, 32'h44332211);

      do_txn(1'b0, 1'b0, 24'hFFFFFE, 32'h0, rd, lat, cf);
      chk("wrap_addr", 32'(last_addr), 32'hFFFFFE);
      chk("wrap_data", rd, 32'hD4C3B2A1);

      // Contention straight out of reset: both hold requests for three grants.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      p0_addr = 24'h000100; p1_addr = 24'h000200; p1_we = 1'b0;
      p0_req = 1'b1; p1_req = 1'b1;
      nack = 0;
      for (int n = 1; n <= 400 && nack < 3; n++) begin
         @(negedge clk);
         if (p0_ack || p1_ack) begin
            ack_t[nack] = n; ack_p[nack] = p1_ack;
            ack_d[nack] = p1_ack ? p1_rdata : p0_rdata;
            nack++;
         end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      chk("rr_count", 32'(nack), 32'd3);
      chk("rr_order", {29'd0, ack_p[0], ack_p[1], ack_p[2]}, 32'b010);
      chk("rr_t0", 32'(ack_t[0]), 32'd57);
      chk("rr_t1", 32'(ack_t[1]), 32'd116);
      chk("rr_t2", 32'(ack_t[2]), 32'd175);
      chk("rr_d0", ack_d[0], 32'h44332211);
      chk("rr_d1", ack_d[1], 32'hDEADBEEF);
      repeat (4) @(negedge clk);

      // Reset during cycle 20 of a read; the held request must restart cleanly.
      p0_addr = 24'h000100; p0_req = 1'b1;
      seen = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (p0_ack) seen = 1'b1;
      end
      reset = 1'b1;
      @(negedge clk);
      chk("rst_csb_high", 32'(spi_csb), 32'd1);
      chk("rst_no_ack", 32'(seen | p0_ack), 32'd0);
      chk("rst_rdata_clr", p0_rdata, 32'd0);
      reset = 1'b0;
      lat = -1;
      for (int n = 1; n <= 200 && lat < 0; n++) begin
         @(negedge clk);
         if (p0_ack) begin
            lat = n; rd = p0_rdata; p0_req = 1'b0;
         end
      end
      chk("rst_reack_cycle", 32'(lat), 32'd57);
      chk("rst_reack_data", rd, 32'h44332211);
      repeat (4) @(negedge clk);

      chk("timing_io_vs_sclk", 32'(tim_err), 32'd0);
      chk("idle_outputs", 32'(idle_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
